stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports D_rs_addr, D_rt_addr  input  5 each  source registers of the D-stage instruction.
REQ-006 SHALL have ports D_rs_tuse, D_rt_tuse  input  2 each  cycles until the D-stage instruction consumes rs/rt; 3 = not used.
REQ-007 SHALL have ports E_wa, M_wa  input  5 each  destination registers in E and M; 0 = no write.
REQ-008 SHALL have ports E_tnew, M_tnew  input  2 each  cycles until the E/M result is available.
REQ-009 SHALL have port D_md  input  1  D-stage instruction uses the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 SHALL have ports E_md_start, E_md_div  input  1 each  mult/div issuing in E this cycle; 1 = divide.
REQ-011 SHALL have port D_flush_req  input  1  request to squash the instruction entering D.
REQ-012 SHALL have ports PC_en, D_REG_STALL, E_flush, D_flush  output  1 each  PC write enable, D-register hold, E-register bubble insert, D-register squash.
REQ-013 SHALL have ports md_busy  output  1, stall_cnt  output  16  HI/LO busy flag; count of stall cycles.

Function
REQ-014 SHALL assert hazard_rs when D_rs_addr != 0, D_rs_addr == E_wa and D_rs_tuse < E_tnew, or when D_rs_addr != 0, D_rs_addr == M_wa and D_rs_tuse < M_tnew; hazard_rt likewise for rt.
REQ-015 SHALL maintain a 4-bit down-counter md_cnt, which loads MULT_CYC or DIV_CYC (per E_md_div) on the posedge where E_md_start = 1 and md_cnt = 0.
REQ-016 SHALL decrement a nonzero md_cnt by 1 per cycle, reaching 0 and never wrapping.
REQ-017 SHALL ignore E_md_start while md_cnt != 0, because the stall logic prevents that case.
REQ-018 SHALL drive md_busy = (md_cnt != 0) | E_md_start combinationally.
REQ-019 SHALL assert stall = hazard_rs | hazard_rt | (D_md & md_busy).
REQ-020 SHALL drive PC_en = !stall, D_REG_STALL = stall and E_flush = stall combinationally, with zero-cycle latency.
REQ-021 SHALL drive D_flush = D_flush_req & !stall, so that a flush is never applied to a held D register; the request remains with the source until it is accepted.
REQ-022 SHALL increment stall_cnt on each posedge with stall = 1, saturating at 16'hFFFF.
REQ-023 SHALL make a stall caused by md_busy last exactly until md_cnt reaches 0, releasing in the cycle where md_cnt == 0 and E_md_start == 0.
REQ-024 SHALL give simultaneous data and HI/LO hazards one combined stall, with no double counting in stall_cnt.

Reset
REQ-025 SHALL clear md_cnt and stall_cnt to 0 immediately when reset asserts, independent of clk.
REQ-026 SHALL hold outputs at PC_en = 1, D_REG_STALL = 0, E_flush = 0, D_flush = 0 and md_busy = 0 during reset, with stall_cnt = 0.
REQ-027 SHALL abandon an in-progress mult/div count when reset asserts mid-operation, and SHALL accept no new load until reset deasserts.

Structure
REQ-028 SHALL take MULT_CYC/DIV_CYC defaults, the tuse/tnew encodings (0-2 = cycles, 3 = none) and the zero-register constant from the shared pipeline package.
REQ-029 SHALL place the md_cnt load/decrement logic in the sub-module md_busy_timer (ports clk, reset, start, is_div, busy), with the hazard comparison kept combinational at the top level.

Verification
REQ-030 SHALL test a load-use hazard: E_wa = 5, E_tnew = 2, D_rs_addr = 5, D_rs_tuse = 0 -> stall = 1, PC_en = 0, E_flush = 1 for one cycle; stall_cnt increments by 1.
REQ-031 SHALL test register zero: E_wa = 0, D_rs_addr = 0, E_tnew = 2, D_rs_tuse = 0 -> no stall.
REQ-032 SHALL test a multiply: E_md_start = 1, E_md_div = 0, then D_md = 1 held -> md_busy high for 6 cycles (start cycle plus 5 countdown cycles), D_REG_STALL released when md_cnt = 0.
REQ-033 SHALL test a divide with async reset after 4 cycles -> md_cnt = 0 and md_busy = 0 immediately, stall deasserts without waiting for clk.
REQ-034 SHALL test flush during stall: D_flush_req = 1 with an active hazard -> D_flush = 0; on the hazard release cycle -> D_flush = 1.
REQ-035 SHALL test saturation: force 65,540 stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline constants and types for the D-stage stall controller.
// Holds the tuse/tnew encoding, the zero-register constant and the HI/LO latency defaults.
package stall_ctrl_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned TIME_W      = 2;
    localparam int unsigned MD_CNT_W    = 4;
    localparam int unsigned STALL_CNT_W = 16;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = REG_ADDR_W'(0);
    localparam logic [TIME_W-1:0]     TIME_NONE = TIME_W'(3);

    // A register source in D: which register, and how many cycles until it is read.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [TIME_W-1:0]     tuse;
    } src_t;

    // A pending write in a later stage: destination and cycles until the result exists.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [TIME_W-1:0]     tnew;
    } dst_t;

    // A source must wait when a younger-than-ready producer targets the same nonzero register.
    // tuse = TIME_NONE (3) can never be below any tnew, so unused sources never stall.
    function automatic logic src_hazard(input src_t src, input dst_t dst);
        return (src.addr != ZERO_REG) && (src.addr == dst.wa) && (src.tuse < dst.tnew);
    endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// HI/LO unit occupancy timer: loads the mult/div latency on issue and counts down to idle.
// busy also covers the issuing cycle itself, before the count has been loaded.
module md_busy_timer
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [MD_CNT_W-1:0] md_cnt;
    logic                cnt_idle;

    assign cnt_idle = (md_cnt == MD_CNT_W'(0));

    // A start seen while counting is dropped; the stall logic keeps that from happening.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= MD_CNT_W'(0);
        end else if (!cnt_idle) begin
            md_cnt <= md_cnt - MD_CNT_W'(1);
        end else if (start) begin
            md_cnt <= is_div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
        end
    end

    assign busy = !reset && (!cnt_idle || start);

endmodule

// File: rtl/stall_ctrl.sv
// Decode-stage stall/flush controller: data hazards against E/M plus HI/LO busy interlock.
// Control outputs are combinational so a hazard takes effect in the same cycle.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  D_rs_addr,
    input  logic [REG_ADDR_W-1:0]  D_rt_addr,
    input  logic [TIME_W-1:0]      D_rs_tuse,
    input  logic [TIME_W-1:0]      D_rt_tuse,
    input  logic [REG_ADDR_W-1:0]  E_wa,
    input  logic [REG_ADDR_W-1:0]  M_wa,
    input  logic [TIME_W-1:0]      E_tnew,
    input  logic [TIME_W-1:0]      M_tnew,
    input  logic                   D_md,
    input  logic                   E_md_start,
    input  logic                   E_md_div,
    input  logic                   D_flush_req,
    output logic                   PC_en,
    output logic                   D_REG_STALL,
    output logic                   E_flush,
    output logic                   D_flush,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    src_t rs_src;
    src_t rt_src;
    dst_t e_dst;
    dst_t m_dst;
    logic hazard_rs;
    logic hazard_rt;
    logic stall;

    assign rs_src = '{addr: D_rs_addr, tuse: D_rs_tuse};
    assign rt_src = '{addr: D_rt_addr, tuse: D_rt_tuse};
    assign e_dst  = '{wa: E_wa, tnew: E_tnew};
    assign m_dst  = '{wa: M_wa, tnew: M_tnew};

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .busy   (md_busy)
    );

    // Data and HI/LO hazards merge into one stall; reset forces the pipeline to run freely.
    always_comb begin
        hazard_rs = 1'b0;
        hazard_rt = 1'b0;
        stall     = 1'b0;
        hazard_rs = src_hazard(rs_src, e_dst) || src_hazard(rs_src, m_dst);
        hazard_rt = src_hazard(rt_src, e_dst) || src_hazard(rt_src, m_dst);
        stall     = !reset && (hazard_rs || hazard_rt || (D_md && md_busy));
    end

    // A squash is held back while D is frozen; the requester keeps asking until it lands.
    always_comb begin
        PC_en       = 1'b1;
        D_REG_STALL = 1'b0;
        E_flush     = 1'b0;
        D_flush     = 1'b0;
        PC_en       = !stall;
        D_REG_STALL = stall;
        E_flush     = stall;
        D_flush     = !reset && D_flush_req && !stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= STALL_CNT_W'(0);
        end else if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: hazards, HI/LO interlock, flush gating, async reset, saturation.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_md, E_md_start, E_md_div, D_flush_req;
    logic        PC_en, D_REG_STALL, E_flush, D_flush, md_busy;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    stall_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs_addr   (D_rs_addr),
        .D_rt_addr   (D_rt_addr),
        .D_rs_tuse   (D_rs_tuse),
        .D_rt_tuse   (D_rt_tuse),
        .E_wa        (E_wa),
        .M_wa        (M_wa),
        .E_tnew      (E_tnew),
        .M_tnew      (M_tnew),
        .D_md        (D_md),
        .E_md_start  (E_md_start),
        .E_md_div    (E_md_div),
        .D_flush_req (D_flush_req),
        .PC_en       (PC_en),
        .D_REG_STALL (D_REG_STALL),
        .E_flush     (E_flush),
        .D_flush     (D_flush),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic s);
        check({tag, ".PC_en"}, 32'(PC_en), 32'(!s));
        check({tag, ".D_REG_STALL"}, 32'(D_REG_STALL), 32'(s));
        check({tag, ".E_flush"}, 32'(E_flush), 32'(s));
    endtask

    // Advance one clock; the caller states whether this cycle should be counted as a stall.
    task automatic step(input bit stalled);
        if (stalled && exp_cnt < 65535) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        D_rs_addr = 5'd0; D_rt_addr = 5'd0; E_wa = 5'd0; M_wa = 5'd0;
        D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; E_tnew = 2'd0; M_tnew = 2'd0;
        D_md = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0; D_flush_req = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        D_flush_req = 1'b1;
        E_md_start  = 1'b1;
        D_md        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_ctrl("reset", 1'b0);
        check("reset.D_flush", 32'(D_flush), 32'd0);
        check("reset.md_busy", 32'(md_busy), 32'd0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        clear_inputs();
        reset = 1'b0;
        step(0);
        check("idle.stall_cnt", 32'(stall_cnt), 32'd0);

        // Load-use on rs against E.
        E_wa = 5'd5; E_tnew = 2'd2; D_rs_addr = 5'd5; D_rs_tuse = 2'd0;
        #1;
        chk_ctrl("loaduse", 1'b1);
        step(1);
        E_wa = 5'd0;
        #1;
        chk_ctrl("loaduse_rel", 1'b0);
        check("loaduse.stall_cnt", 32'(stall_cnt), 32'd1);
        step(0);
        check("loaduse_after.stall_cnt", 32'(stall_cnt), 32'd1);

        // Register zero never stalls.
        E_wa = 5'd0; D_rs_addr = 5'd0; E_tnew = 2'd2; D_rs_tuse = 2'd0;
        #1;
        chk_ctrl("zero_reg", 1'b0);
        // tuse equal to tnew is satisfied by forwarding.
        E_wa = 5'd5; D_rs_addr = 5'd5; E_tnew = 2'd2; D_rs_tuse = 2'd2;
        #1;
        chk_ctrl("tuse_eq_tnew", 1'b0);
        // rt against M.
        clear_inputs();
        M_wa = 5'd7; M_tnew = 2'd1; D_rt_addr = 5'd7; D_rt_tuse = 2'd0;
        #1;
        chk_ctrl("rt_vs_m", 1'b1);
        D_rt_tuse = 2'd3;
        #1;
        chk_ctrl("rt_unused", 1'b0);
        D_rt_tuse = 2'd0; D_rt_addr = 5'd8;
        #1;
        chk_ctrl("rt_other_reg", 1'b0);
        clear_inputs();
        step(0);

        // Multiply: start cycle plus 5 countdown cycles busy, with a mid-run data hazard
        // and an ignored start pulse.
        E_md_start = 1'b1; E_md_div = 1'b0;
        #1;
        check("mult.start_busy", 32'(md_busy), 32'd1);
        chk_ctrl("mult.start", 1'b0);
        step(0);
        E_md_start = 1'b0; D_md = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                E_wa = 5'd9; E_tnew = 2'd1; D_rt_addr = 5'd9; D_rt_tuse = 2'd0;
            end
            if (i == 3) begin
                E_wa = 5'd0; E_md_start = 1'b1; E_md_div = 1'b1;
            end
            if (i == 4) E_md_start = 1'b0;
            #1;
            check($sformatf("mult.busy%0d", i), 32'(md_busy), 32'd1);
            chk_ctrl($sformatf("mult.stall%0d", i), 1'b1);
            step(1);
        end
        #1;
        check("mult.done_busy", 32'(md_busy), 32'd0);
        chk_ctrl("mult.release", 1'b0);
        check("mult.stall_cnt", 32'(stall_cnt), 32'd6);
        clear_inputs();
        step(0);

        // Divide interrupted by async reset in its fourth cycle.
        E_md_start = 1'b1; E_md_div = 1'b1;
        step(0);
        E_md_start = 1'b0; D_md = 1'b1;
        repeat (3) step(1);
        check("div.pre_reset_cnt", 32'(stall_cnt), 32'd9);
        check("div.busy", 32'(md_busy), 32'd1);
        chk_ctrl("div.stall", 1'b1);
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        check("div.rst_busy", 32'(md_busy), 32'd0);
        chk_ctrl("div.rst", 1'b0);
        check("div.rst_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
        #1;
        check("div.post_busy", 32'(md_busy), 32'd0);
        chk_ctrl("div.post", 1'b0);
        step(0);
        check("div.no_reload", 32'(md_busy), 32'd0);
        check("div.post_cnt", 32'(stall_cnt), 32'd0);
        clear_inputs();

        // Flush held back while stalled, accepted on release.
        D_flush_req = 1'b1;
        E_wa = 5'd5; E_tnew = 2'd2; D_rs_addr = 5'd5; D_rs_tuse = 2'd1;
        #1;
        check("flush.held", 32'(D_flush), 32'd0);
        chk_ctrl("flush.stall", 1'b1);
        step(1);
        E_tnew = 2'd1;
        #1;
        check("flush.accept", 32'(D_flush), 32'd1);
        chk_ctrl("flush.release", 1'b0);
        check("flush.stall_cnt", 32'(stall_cnt), 32'd1);
        step(0);
        D_flush_req = 1'b0;
        #1;
        check("flush.idle", 32'(D_flush), 32'd0);

        // Saturation over 65540 stall cycles.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_cnt = 0;
        clear_inputs();
        E_wa = 5'd3; E_tnew = 2'd2; D_rs_addr = 5'd3; D_rs_tuse = 2'd0;
        repeat (65534) step(1);
        check("sat.fffe", 32'(stall_cnt), 32'h0000_FFFE);
        step(1);
        check("sat.ffff", 32'(stall_cnt), 32'h0000_FFFF);
        repeat (5) step(1);
        check("sat.hold", 32'(stall_cnt), 32'h0000_FFFF);
        check("sat.model", 32'(stall_cnt), 32'(exp_cnt));
        chk_ctrl("sat.stall", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
